// File: rtl/alut_lookup_master.sv
// alut_lookup_master
// ------------------
// APB master that serves one frame-lookup request at a time for the ALUT.
// For each request it does the following:
//   - programs the destination and source MAC registers,
//   - writes the check command,
//   - polls the status register until the check is no longer active
//     (or gives up after POLL_MAX busy reads),
//   - reads back the destination port vector,
//   - presents the result on a valid/ready response channel.
//
// Ports
//   pclk17, n_p_reset17          clock, asynchronous active-low reset
//   req_valid17 / req_ready17    request handshake
//   req_d_addr17, req_s_addr17   destination / source MAC (48 bits)
//   req_s_port17                 source port (2 bits)
//   rsp_valid17 / rsp_ready17    response handshake
//   rsp_d_port17                 destination port vector (5 bits)
//   rsp_timeout17                lookup timed out, rsp_d_port17 forced to 0
//   busy17                       a lookup or response is in progress
//   psel17 .. pwdata17, prdata17 APB master port. There is no pready,
//                                so every transfer is SETUP + ACCESS.
`timescale 1ns/1ps

module alut_lookup_master #(
  parameter logic [6:0]  REG_CMD     = 7'h00,
  parameter logic [6:0]  REG_DADDR_L = 7'h08,
  parameter logic [6:0]  REG_DADDR_H = 7'h0C,
  parameter logic [6:0]  REG_SADDR_L = 7'h10,
  parameter logic [6:0]  REG_SADDR_H = 7'h14,
  parameter logic [6:0]  REG_STATUS  = 7'h18,
  parameter logic [6:0]  REG_DPORT   = 7'h1C,
  parameter logic [31:0] CMD_CHECK   = 32'h1,
  parameter int          POLL_MAX    = 64
) (
  input  logic        pclk17,
  input  logic        n_p_reset17,
  input  logic        req_valid17,
  output logic        req_ready17,
  input  logic [47:0] req_d_addr17,
  input  logic [47:0] req_s_addr17,
  input  logic [1:0]  req_s_port17,
  output logic        rsp_valid17,
  input  logic        rsp_ready17,
  output logic [4:0]  rsp_d_port17,
  output logic        rsp_timeout17,
  output logic        busy17,
  output logic        psel17,
  output logic        penable17,
  output logic        pwrite17,
  output logic [6:0]  paddr17,
  output logic [31:0] pwdata17,
  input  logic [31:0] prdata17
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_t;

  // Which register the current APB transfer targets; walks the fixed
  // lookup sequence.
  typedef enum logic [2:0] {
    OP_DADDR_L,
    OP_DADDR_H,
    OP_SADDR_L,
    OP_SADDR_H,
    OP_CMD,
    OP_STATUS,
    OP_DPORT
  } op_t;

  // Counter value that, when one more busy read completes, reaches POLL_MAX.
  localparam logic [7:0] POLL_LAST = 8'(POLL_MAX - 1);

  state_t      state_reg, state_next;
  op_t         op_reg, op_next;
  logic [7:0]  poll_cnt_reg, poll_cnt_next;
  logic [47:0] d_addr_reg, d_addr_next;
  logic [47:0] s_addr_reg, s_addr_next;
  logic [1:0]  s_port_reg, s_port_next;
  logic [4:0]  rsp_d_port_reg, rsp_d_port_next;
  logic        rsp_timeout_reg, rsp_timeout_next;

  logic req_fire;
  logic xfer_write;

  // Status bits above bit0 and d_port bits above [4] carry no meaning here.
  logic unused_prdata;
  assign unused_prdata = ^prdata17[31:5];

  // --------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------
  always_ff @(posedge pclk17 or negedge n_p_reset17) begin
    if (!n_p_reset17) begin
      state_reg       <= IDLE;
      op_reg          <= OP_DADDR_L;
      poll_cnt_reg    <= 8'd0;
      d_addr_reg      <= 48'd0;
      s_addr_reg      <= 48'd0;
      s_port_reg      <= 2'd0;
      rsp_d_port_reg  <= 5'd0;
      rsp_timeout_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      op_reg          <= op_next;
      poll_cnt_reg    <= poll_cnt_next;
      d_addr_reg      <= d_addr_next;
      s_addr_reg      <= s_addr_next;
      s_port_reg      <= s_port_next;
      rsp_d_port_reg  <= rsp_d_port_next;
      rsp_timeout_reg <= rsp_timeout_next;
    end
  end

  // --------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------
  // RESP is a separate state, so IDLE always means "no pending response".
  assign req_ready17 = (state_reg == IDLE);
  assign req_fire    = req_valid17 && req_ready17;

  always_comb begin
    state_next       = state_reg;
    op_next          = op_reg;
    poll_cnt_next    = poll_cnt_reg;
    d_addr_next      = d_addr_reg;
    s_addr_next      = s_addr_reg;
    s_port_next      = s_port_reg;
    rsp_d_port_next  = rsp_d_port_reg;
    rsp_timeout_next = rsp_timeout_reg;

    case (state_reg)
      IDLE: begin
        if (req_fire) begin
          d_addr_next = req_d_addr17;
          s_addr_next = req_s_addr17;
          s_port_next = req_s_port17;
          op_next     = OP_DADDR_L;
          state_next  = SETUP;
        end
      end

      SETUP: begin
        state_next = ACCESS;
      end

      // End of ACCESS: prdata17 is valid here for read transfers.
      // Every path out of ACCESS goes straight to the next SETUP, so
      // transfers run back-to-back.
      ACCESS: begin
        state_next = SETUP;
        case (op_reg)
          OP_DADDR_L: op_next = OP_DADDR_H;
          OP_DADDR_H: op_next = OP_SADDR_L;
          OP_SADDR_L: op_next = OP_SADDR_H;
          OP_SADDR_H: op_next = OP_CMD;
          OP_CMD:     op_next = OP_STATUS;
          OP_STATUS: begin
            if (prdata17[0]) begin
              poll_cnt_next = poll_cnt_reg + 8'd1;
              if (poll_cnt_reg == POLL_LAST) begin
                // Check never finished: report a timeout and skip DPORT.
                rsp_d_port_next  = 5'd0;
                rsp_timeout_next = 1'b1;
                state_next       = RESP;
              end
            end else begin
              op_next = OP_DPORT;
            end
          end
          OP_DPORT: begin
            rsp_d_port_next  = prdata17[4:0];
            rsp_timeout_next = 1'b0;
            state_next       = RESP;
          end
          default: state_next = IDLE;
        endcase
      end

      RESP: begin
        if (rsp_ready17) begin
          poll_cnt_next = 8'd0;
          state_next    = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // --------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------
  assign psel17        = (state_reg == SETUP) || (state_reg == ACCESS);
  assign penable17     = (state_reg == ACCESS);
  assign rsp_valid17   = (state_reg == RESP);
  assign busy17        = (state_reg != IDLE);
  assign rsp_d_port17  = rsp_d_port_reg;
  assign rsp_timeout17 = rsp_timeout_reg;

  // The first five operations are writes; STATUS and DPORT are reads.
  assign xfer_write = (op_reg == OP_DADDR_L) || (op_reg == OP_DADDR_H) ||
                      (op_reg == OP_SADDR_L) || (op_reg == OP_SADDR_H) ||
                      (op_reg == OP_CMD);
  assign pwrite17   = psel17 && xfer_write;

  // Address and data depend only on op_reg, which is held across SETUP
  // and ACCESS. Both are forced to 0 outside a transfer.
  always_comb begin
    paddr17  = 7'd0;
    pwdata17 = 32'd0;
    if (psel17) begin
      case (op_reg)
        OP_DADDR_L: begin
          paddr17  = REG_DADDR_L;
          pwdata17 = d_addr_reg[31:0];
        end
        OP_DADDR_H: begin
          paddr17  = REG_DADDR_H;
          pwdata17 = {16'd0, d_addr_reg[47:32]};
        end
        OP_SADDR_L: begin
          paddr17  = REG_SADDR_L;
          pwdata17 = s_addr_reg[31:0];
        end
        OP_SADDR_H: begin
          paddr17  = REG_SADDR_H;
          pwdata17 = {14'd0, s_port_reg, s_addr_reg[47:32]};
        end
        OP_CMD: begin
          paddr17  = REG_CMD;
          pwdata17 = CMD_CHECK;
        end
        OP_STATUS: paddr17 = REG_STATUS;
        OP_DPORT:  paddr17 = REG_DPORT;
        default: begin
          paddr17  = 7'd0;
          pwdata17 = 32'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alut_lookup_master.sv
// Directed testbench for alut_lookup_master (POLL_MAX = 4).
// A small ALUT responder model answers status/d_port reads. An APB monitor
// logs every completed transfer and counts SETUP/ACCESS stability errors.
`timescale 1ns/1ps

module tb_alut_lookup_master;

  logic        pclk17 = 1'b0;
  logic        n_p_reset17;
  logic        req_valid17;
  logic        req_ready17;
  logic [47:0] req_d_addr17;
  logic [47:0] req_s_addr17;
  logic [1:0]  req_s_port17;
  logic        rsp_valid17;
  logic        rsp_ready17;
  logic [4:0]  rsp_d_port17;
  logic        rsp_timeout17;
  logic        busy17;
  logic        psel17;
  logic        penable17;
  logic        pwrite17;
  logic [6:0]  paddr17;
  logic [31:0] pwdata17;
  logic [31:0] prdata17;

  alut_lookup_master #(.POLL_MAX(4)) dut (
    .pclk17        (pclk17),
    .n_p_reset17   (n_p_reset17),
    .req_valid17   (req_valid17),
    .req_ready17   (req_ready17),
    .req_d_addr17  (req_d_addr17),
    .req_s_addr17  (req_s_addr17),
    .req_s_port17  (req_s_port17),
    .rsp_valid17   (rsp_valid17),
    .rsp_ready17   (rsp_ready17),
    .rsp_d_port17  (rsp_d_port17),
    .rsp_timeout17 (rsp_timeout17),
    .busy17        (busy17),
    .psel17        (psel17),
    .penable17     (penable17),
    .pwrite17      (pwrite17),
    .paddr17       (paddr17),
    .pwdata17      (pwdata17),
    .prdata17      (prdata17)
  );

  always #5 pclk17 = ~pclk17;

  int n_assert = 0;
  int n_fail   = 0;

  // Responder model controls (written only by the stimulus block).
  int          busy_target = 0;
  int          stat_base   = 0;
  logic [31:0] dport_word  = 32'h0;
  int          log_base    = 0;

  // Monitor state (written only by the monitor).
  int          stat_reads = 0;
  int          log_n      = 0;
  int          stab_err   = 0;
  logic [6:0]  log_addr [0:511];
  logic        log_wr   [0:511];
  logic [31:0] log_data [0:511];
  logic        s_valid  = 1'b0;
  logic [6:0]  s_addr;
  logic        s_wr;
  logic [31:0] s_data;

  // The status register reports "active" for the first busy_target reads
  // of a lookup. Upper status bits are always set; the DUT must ignore them.
  always_comb begin
    prdata17 = 32'hDEAD_BEEF;
    if (paddr17 == 7'h18)
      prdata17 = 32'hFFFF_FFFE | {31'h0, ((stat_reads - stat_base) < busy_target)};
    else if (paddr17 == 7'h1C)
      prdata17 = dport_word;
  end

  always @(posedge pclk17) begin
    if (psel17 && !penable17) begin
      s_addr  <= paddr17;
      s_wr    <= pwrite17;
      s_data  <= pwdata17;
      s_valid <= 1'b1;
    end else if (psel17 && penable17) begin
      if (!s_valid || s_addr !== paddr17 || s_wr !== pwrite17 || s_data !== pwdata17)
        stab_err <= stab_err + 1;
      s_valid <= 1'b0;
      if (log_n < 512) begin
        log_addr[log_n] <= paddr17;
        log_wr[log_n]   <= pwrite17;
        log_data[log_n] <= pwdata17;
        log_n           <= log_n + 1;
      end
      if (paddr17 == 7'h18 && !pwrite17)
        stat_reads <= stat_reads + 1;
    end else begin
      s_valid <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_xfer(input string tag, input int idx, input logic [6:0] a,
                            input logic w, input logic [31:0] d);
    check(tag, {24'h0, log_addr[log_base + idx], 7'h0, log_wr[log_base + idx], log_data[log_base + idx]},
          {24'h0, a, 7'h0, w, d});
  endtask

  task automatic prep(input int busy_reads, input logic [31:0] dport);
    log_base    = log_n;
    stat_base   = stat_reads;
    busy_target = busy_reads;
    dport_word  = dport;
  endtask

  // Called at a negedge with the DUT idle. Returns at the negedge following
  // the handshake edge, i.e. in cycle 1 of the lookup.
  task automatic send_req(input logic [47:0] d, input logic [47:0] s, input logic [1:0] p);
    req_d_addr17 = d;
    req_s_addr17 = s;
    req_s_port17 = p;
    req_valid17  = 1'b1;
    check("req_ready_before", {63'h0, req_ready17}, 64'h1);
    @(negedge pclk17);
    req_valid17 = 1'b0;
  endtask

  // Cycle number (handshake cycle = 0) in which rsp_valid17 is first seen.
  task automatic wait_rsp(output int cyc);
    cyc = 1;
    while (!rsp_valid17 && cyc < 300) begin
      @(negedge pclk17);
      cyc++;
    end
  endtask

  task automatic ack_rsp();
    rsp_ready17 = 1'b1;
    @(negedge pclk17);
    rsp_ready17 = 1'b0;
    check("rsp_valid_after_ack", {63'h0, rsp_valid17}, 64'h0);
    check("req_ready_after_ack", {63'h0, req_ready17}, 64'h1);
  endtask

  int cyc;

  initial begin
    n_p_reset17  = 1'b0;
    req_valid17  = 1'b0;
    rsp_ready17  = 1'b0;
    req_d_addr17 = 48'h0;
    req_s_addr17 = 48'h0;
    req_s_port17 = 2'd0;

    // ---------------- reset ----------------
    repeat (3) @(negedge pclk17);
    check("rst_req_ready", {63'h0, req_ready17}, 64'h1);
    check("rst_psel",      {63'h0, psel17},      64'h0);
    check("rst_penable",   {63'h0, penable17},   64'h0);
    check("rst_rsp_valid", {63'h0, rsp_valid17}, 64'h0);
    check("rst_busy",      {63'h0, busy17},      64'h0);
    n_p_reset17 = 1'b1;
    @(negedge pclk17);

    // ---------------- basic lookup ----------------
    prep(0, 32'hFFFF_FFE4);
    send_req(48'h0011_2233_4455, 48'hAABB_CCDD_EEFF, 2'd2);
    check("basic_setup_psel",    {63'h0, psel17},    64'h1);
    check("basic_setup_penable", {63'h0, penable17}, 64'h0);
    check("basic_setup_paddr",   {57'h0, paddr17},   64'h08);
    check("basic_busy",          {63'h0, busy17},    64'h1);
    check("basic_req_ready",     {63'h0, req_ready17}, 64'h0);
    wait_rsp(cyc);
    check("basic_latency", 64'(cyc), 64'd15);
    check("basic_d_port",  {59'h0, rsp_d_port17}, 64'h04);
    check("basic_timeout", {63'h0, rsp_timeout17}, 64'h0);
    ack_rsp();
    check("basic_xfer_count", 64'(log_n - log_base), 64'd7);
    check_xfer("basic_x0", 0, 7'h08, 1'b1, 32'h2233_4455);
    check_xfer("basic_x1", 1, 7'h0C, 1'b1, 32'h0000_0011);
    check_xfer("basic_x2", 2, 7'h10, 1'b1, 32'hCCDD_EEFF);
    check_xfer("basic_x3", 3, 7'h14, 1'b1, 32'h0002_AABB);
    check_xfer("basic_x4", 4, 7'h00, 1'b1, 32'h0000_0001);
    check_xfer("basic_x5", 5, 7'h18, 1'b0, 32'h0000_0000);
    check_xfer("basic_x6", 6, 7'h1C, 1'b0, 32'h0000_0000);

    // ---------------- multi-poll ----------------
    prep(3, 32'h0000_0033);
    send_req(48'h1234_5678_9ABC, 48'h0000_0000_0001, 2'd1);
    wait_rsp(cyc);
    check("multi_latency", 64'(cyc), 64'd21);
    check("multi_d_port",  {59'h0, rsp_d_port17}, 64'h13);
    check("multi_timeout", {63'h0, rsp_timeout17}, 64'h0);
    ack_rsp();
    check("multi_xfer_count", 64'(log_n - log_base), 64'd10);
    check_xfer("multi_x3", 3, 7'h14, 1'b1, 32'h0001_0000);
    check_xfer("multi_x5", 5, 7'h18, 1'b0, 32'h0);
    check_xfer("multi_x8", 8, 7'h18, 1'b0, 32'h0);
    check_xfer("multi_x9", 9, 7'h1C, 1'b0, 32'h0);

    // ---------------- timeout ----------------
    prep(1000, 32'h0000_001F);
    send_req(48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF, 2'd3);
    wait_rsp(cyc);
    check("to_latency", 64'(cyc), 64'd19);
    check("to_timeout", {63'h0, rsp_timeout17}, 64'h1);
    check("to_d_port",  {59'h0, rsp_d_port17}, 64'h0);
    ack_rsp();
    check("to_xfer_count", 64'(log_n - log_base), 64'd9);
    check_xfer("to_x1", 1, 7'h0C, 1'b1, 32'h0000_FFFF);
    check_xfer("to_x3", 3, 7'h14, 1'b1, 32'h0003_FFFF);
    check_xfer("to_x8", 8, 7'h18, 1'b0, 32'h0);

    // ---------------- backpressure ----------------
    prep(0, 32'h0000_0008);
    send_req(48'h0000_0000_0AAA, 48'h0000_0000_0555, 2'd0);
    wait_rsp(cyc);
    check("bp_latency", 64'(cyc), 64'd15);
    check("bp_d_port",  {59'h0, rsp_d_port17}, 64'h08);
    req_d_addr17 = 48'h0000_0000_0BBB;
    req_s_addr17 = 48'h0000_0000_0CCC;
    req_s_port17 = 2'd1;
    req_valid17  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge pclk17);
      check("bp_hold_valid",     {63'h0, rsp_valid17},   64'h1);
      check("bp_hold_d_port",    {59'h0, rsp_d_port17},  64'h08);
      check("bp_hold_timeout",   {63'h0, rsp_timeout17}, 64'h0);
      check("bp_hold_req_ready", {63'h0, req_ready17},   64'h0);
    end
    prep(0, 32'h0000_0011);
    rsp_ready17 = 1'b1;
    @(negedge pclk17);
    rsp_ready17 = 1'b0;
    check("bp_rsp_dropped", {63'h0, rsp_valid17}, 64'h0);
    check("bp_req_ready",   {63'h0, req_ready17}, 64'h1);
    @(negedge pclk17);
    req_valid17 = 1'b0;
    check("bp_second_psel",   {63'h0, psel17},   64'h1);
    check("bp_second_paddr",  {57'h0, paddr17},  64'h08);
    check("bp_second_pwdata", {32'h0, pwdata17}, 64'h0000_0BBB);
    wait_rsp(cyc);
    check("bp_second_latency", 64'(cyc), 64'd15);
    check("bp_second_d_port",  {59'h0, rsp_d_port17}, 64'h11);
    ack_rsp();

    // ---------------- reset mid-operation ----------------
    prep(0, 32'h0000_0002);
    send_req(48'h0000_1111_2222, 48'h0000_3333_4444, 2'd2);
    repeat (5) @(negedge pclk17);
    check("mid_access_paddr",   {57'h0, paddr17},   64'h10);
    check("mid_access_penable", {63'h0, penable17}, 64'h1);
    #2 n_p_reset17 = 1'b0;
    #1;
    check("mid_rst_psel",    {63'h0, psel17},    64'h0);
    check("mid_rst_penable", {63'h0, penable17}, 64'h0);
    check("mid_rst_busy",    {63'h0, busy17},    64'h0);
    @(negedge pclk17);
    @(negedge pclk17);
    n_p_reset17 = 1'b1;
    repeat (3) @(negedge pclk17);
    check("mid_no_stale_rsp", {63'h0, rsp_valid17}, 64'h0);
    check("mid_idle_psel",    {63'h0, psel17},      64'h0);
    prep(0, 32'h0000_001E);
    send_req(48'h0000_5555_6666, 48'h0000_7777_8888, 2'd3);
    wait_rsp(cyc);
    check("mid_fresh_latency", 64'(cyc), 64'd15);
    check("mid_fresh_d_port",  {59'h0, rsp_d_port17}, 64'h1E);
    ack_rsp();
    check("mid_fresh_count", 64'(log_n - log_base), 64'd7);
    check_xfer("mid_fresh_x0", 0, 7'h08, 1'b1, 32'h5555_6666);

    check("apb_stability_errors", 64'(stab_err), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/alut_lookup_master.md
Name: alut_lookup_master

Overview:
- APB master that sits directly upstream of the ALUT address-lookup block and is the only device driving its APB port.
- Accepts one frame-lookup request at a time from the switch datapath: destination MAC, source MAC and source port.
- Programs the ALUT registers, issues the check command and polls status until the check completes.
- Reads back the destination port vector and returns it to the datapath over a valid/ready response interface.

Parameters:
- REG_CMD, 7'h00, ALUT command register offset
- REG_DADDR_L, 7'h08, d_addr[31:0] offset
- REG_DADDR_H, 7'h0C, d_addr[47:32] offset, in pwdata[15:0]
- REG_SADDR_L, 7'h10, s_addr[31:0] offset
- REG_SADDR_H, 7'h14, s_addr[47:32] in pwdata[15:0], s_port in pwdata[17:16]
- REG_STATUS, 7'h18, status offset; bit0 = address check active
- REG_DPORT, 7'h1C, d_port offset; d_port in prdata[4:0]
- CMD_CHECK, 32'h1, value written to REG_CMD to start a check
- POLL_MAX, 64, maximum busy status reads before timeout (2..255)

Ports:
- pclk17  in  1  clock
- n_p_reset17  in  1  asynchronous active-low reset
- req_valid17  in  1  lookup request valid
- req_ready17  out  1  request accepted when valid & ready
- req_d_addr17  in  48  destination MAC
- req_s_addr17  in  48  source MAC
- req_s_port17  in  2  source port
- rsp_valid17  out  1  response valid
- rsp_ready17  in  1  response consumed when valid & ready
- rsp_d_port17  out  5  destination port vector
- rsp_timeout17  out  1  lookup timed out; rsp_d_port17 is 0
- busy17  out  1  transaction in progress (state != IDLE)
- psel17  out  1  APB select
- penable17  out  1  APB enable
- pwrite17  out  1  APB write
- paddr17  out  7  APB address
- pwdata17  out  32  APB write data
- prdata17  in  32  APB read data

Behaviour:
- Reset (asynchronous, active-low): all outputs 0 except req_ready17 = 1. State IDLE, poll counter 0, capture registers 0.
- Reset asserted mid-transfer: psel17/penable17 drop immediately; any pending response is discarded.
- APB protocol: the ALUT has no pready, so every transfer is exactly 2 cycles: SETUP (psel=1, penable=0), then ACCESS (psel=1, penable=1).
  - paddr, pwrite and pwdata are stable across both phases.
  - prdata17 is sampled at the end of ACCESS.
  - Unused pwdata bits are 0.
  - Read transfers drive pwdata17 = 0.
- req_ready17 = 1 only in IDLE with rsp_valid17 = 0. On handshake, d_addr/s_addr/s_port are captured and the next cycle is SETUP of the first write.
- Write order, each transfer back-to-back with no idle cycle:
  1. DADDR_L
  2. DADDR_H
  3. SADDR_L
  4. SADDR_H
  5. CMD (CMD_CHECK)
- POLL: read REG_STATUS immediately after the CMD ACCESS.
  - Each completed read with bit0 = 1 increments the poll counter.
  - bit0 = 0: go to read REG_DPORT.
  - Counter reaches POLL_MAX with bit0 still 1: go to RESP with rsp_timeout17 = 1, rsp_d_port17 = 0, and no DPORT read.
- DPORT read: rsp_d_port17 = prdata17[4:0], rsp_timeout17 = 0; go to RESP.
- RESP: rsp_valid17 is held with stable data until rsp_ready17.
  - On handshake: rsp_valid17 drops, counter clears, return to IDLE, req_ready17 = 1 the next cycle.
  - rsp_ready17 already high when rsp_valid17 rises: handshake completes in the first RESP cycle.
- Latency, request handshake to rsp_valid17 (no stall, first poll idle): 10 write cycles + 2 poll + 2 DPORT read = 14 cycles, so rsp_valid17 is high in cycle 15.
  - Each additional busy poll adds 2 cycles.
  - Timeout case: 10 + 2*POLL_MAX cycles.
- No request is accepted while busy17 = 1; req_valid17 held high is simply stalled.
- req_valid17 may drop without a handshake; nothing is captured.
- Status bits other than bit0 are ignored. d_port bits above [4] are ignored.

Test Plan:
- Reset: pulse n_p_reset17 low for 3 cycles -> req_ready17 = 1; psel17, penable17, rsp_valid17 and busy17 all 0.
- Basic lookup: d_addr 48'h0011_2233_4455, s_addr 48'hAABB_CCDD_EEFF, s_port 2; status returns bit0 = 0, d_port = 5'b0_0100.
  - Write sequence: 0x08 ← 32'h2233_4455; 0x0C ← 32'h0000_0011; 0x10 ← 32'hCCDD_EEFF; 0x14 ← 32'h0002_AABB; 0x00 ← 32'h1.
  - Then one read of 0x18, one read of 0x1C.
  - rsp_valid17 high in cycle 15 after the handshake, with rsp_d_port17 = 5'h04.
- Multi-poll: status returns bit0 = 1 for 3 reads, then 0 -> 4 status reads; response is 6 cycles later than the basic lookup.
- Timeout: status bit0 held at 1, POLL_MAX = 4 -> exactly 4 status reads, no DPORT read, rsp_timeout17 = 1, rsp_d_port17 = 0.
- Backpressure: rsp_ready17 low for 5 cycles while a new req_valid17 is held high -> rsp_valid17 and its data stay stable, req_ready17 stays 0, and the second request is accepted the cycle after the response handshake.
- Reset mid-op: assert n_p_reset17 during the SADDR_L ACCESS phase -> psel17/penable17 go to 0 asynchronously; after release a fresh lookup completes normally with no stale response.
